// File: rtl/hyperbus_cfg_master.sv
// hyperbus_cfg_master
//   Register-bus initiator for the Hyperbus configuration register file.
//   Commands from a local controller (boot sequencer, debug bridge) are
//   buffered in a small FIFO and issued one at a time on reg_req_o/reg_rsp_i.
//   Each command produces exactly one response, and responses come back in
//   command order.
//
// Ports
//   clk_i, rst_ni              clock, async active-low reset
//   cmd_valid_i/cmd_ready_o    command handshake (write, addr, wdata, wstrb)
//   rsp_valid_o/rsp_ready_i    response handshake (rdata, error, timeout)
//   reg_req_o/reg_rsp_i        register bus towards the config regfile
//   busy_o                     FIFO non-empty or a command in flight
//
// Build option
//   HYPERBUS_CFG_MST_VERIFY_EN: when defined, every write that completes
//   without error is read back from the same address. The response carries
//   the read-back data and flags an error on a strobed-byte mismatch.
//
// State table
//   state     | meaning
//   ST_IDLE   | waiting for a queued command; pops the FIFO head
//   ST_REQ    | request valid on the register bus, waiting for ready
//   ST_VERIFY | read-back of the just-written address (VERIFY_EN builds only)
//   ST_RSP    | response valid, waiting for rsp_ready_i

package reg_intf_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } req_a32_d32;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } rsp_d32;
endpackage

module hyperbus_cfg_master #(
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_write_i,
  input  logic [31:0]              cmd_addr_i,
  input  logic [31:0]              cmd_wdata_i,
  input  logic [3:0]               cmd_wstrb_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_error_o,
  output logic                     rsp_timeout_o,
  output reg_intf_pkg::req_a32_d32 reg_req_o,
  input  reg_intf_pkg::rsp_d32     reg_rsp_i,
  output logic                     busy_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(FifoDepth);
  // The counter reaching TimeoutCycles-1 is the increment made on this value.
  localparam logic [CntW-1:0] CntLast   = CntW'(TimeoutCycles - 2);

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_RSP    = 2'd2,
    ST_VERIFY = 2'd3
  } state_e;

  state_e          state_q, state_d;
  cmd_t            mem_q [FifoDepth];
  cmd_t            mem_d [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            cmd_ready_q, cmd_ready_d;
  cmd_t            hold_q, hold_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            push;
  logic            pop;

`ifdef HYPERBUS_CFG_MST_VERIFY_EN
  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction
`endif

  // cmd_ready is a flop holding "not full" for the next cycle, so it has no
  // combinational path from either handshake and reads 0 while in reset.
  assign push = cmd_valid_i & cmd_ready_q;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{write: cmd_write_i, addr: cmd_addr_i,
                          wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
    cmd_ready_d = (count_d != FullCount);
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    cnt_d         = cnt_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop           = 1'b1;
          hold_d        = mem_q[rd_ptr_q];
          cnt_d         = '0;
          rsp_rdata_d   = '0;
          rsp_error_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        if (reg_rsp_i.ready) begin
          rsp_error_d = reg_rsp_i.error;
          if (!hold_q.write) rsp_rdata_d = reg_rsp_i.rdata;
          state_d = ST_RSP;
`ifdef HYPERBUS_CFG_MST_VERIFY_EN
          if (hold_q.write && !reg_rsp_i.error) begin
            cnt_d   = '0;
            state_d = ST_VERIFY;
          end
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = ST_RSP;
          end
        end
      end
`ifdef HYPERBUS_CFG_MST_VERIFY_EN
      ST_VERIFY: begin
        if (reg_rsp_i.ready) begin
          rsp_rdata_d = reg_rsp_i.rdata;
          rsp_error_d = reg_rsp_i.error |
                        (|((reg_rsp_i.rdata ^ hold_q.wdata) & byte_mask(hold_q.wstrb)));
          state_d     = ST_RSP;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            rsp_error_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            state_d       = ST_RSP;
          end
        end
      end
`endif
      ST_RSP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields come straight from the holding registers, so they cannot
  // move while valid is high; reset clears valid without waiting for a clock.
  always_comb begin
    reg_req_o = '0;
    if (state_q == ST_REQ) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = hold_q.addr;
      reg_req_o.write = hold_q.write;
      if (hold_q.write) begin
        reg_req_o.wdata = hold_q.wdata;
        reg_req_o.wstrb = hold_q.wstrb;
      end
    end
`ifdef HYPERBUS_CFG_MST_VERIFY_EN
    else if (state_q == ST_VERIFY) begin
      reg_req_o.valid = 1'b1;
      reg_req_o.addr  = hold_q.addr;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      cmd_ready_q   <= 1'b0;
      hold_q        <= '0;
      cnt_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      cmd_ready_q   <= cmd_ready_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = (state_q == ST_RSP);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = (count_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_hyperbus_cfg_master.sv
// Bench for hyperbus_cfg_master: directed scenarios plus a randomized run,
// checked against a queue of expected responses computed at push time from a
// word-array model of the register file.

module tb_hyperbus_cfg_master;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        busy;
  reg_intf_pkg::req_a32_d32 reg_req;
  reg_intf_pkg::rsp_d32     reg_rsp;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    logic        timeout;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [64];
  logic [31:0] dev_mem [64];
  int          checks = 0;
  int          failures = 0;
  bit          stall;
  bit          hold_rsp;
  int          max_wait;
  int          wait_left;
  logic [31:0] corrupt;
  logic        dev_ready;

  always #5 clk = ~clk;

  hyperbus_cfg_master #(.FifoDepth(Depth), .TimeoutCycles(Tmo)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout),
    .reg_req_o(reg_req), .reg_rsp_i(reg_rsp), .busy_o(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response from the register-file rules; mapped space is 0x000-0x0FF.
  function automatic void add_expected(input logic wr, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] rb;
    bit          mapped = (addr < 32'h100);
    int          idx = int'(addr[7:2]);
    e = '{rdata: 32'h0, error: 1'b0, timeout: 1'b0};
    for (int b = 0; b < 4; b++) mask[8*b +: 8] = wstrb[b] ? 8'hFF : 8'h00;
    if (stall) begin
      e.error = 1'b1;
      e.timeout = 1'b1;
    end else if (!mapped) begin
      e.error = 1'b1;
    end else if (wr) begin
      model_mem[idx] = (model_mem[idx] & ~mask) | (wdata & mask);
`ifdef HYPERBUS_CFG_MST_VERIFY_EN
      rb      = model_mem[idx] ^ corrupt;
      e.rdata = rb;
      e.error = ((rb ^ wdata) & mask) != 32'h0;
`else
      rb = 32'h0;
`endif
    end else begin
      e.rdata = model_mem[idx] ^ corrupt;
    end
    exp_q.push_back(e);
  endfunction

  task automatic push_cmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", {31'h0, cmd_ready}, 32'h1);
    if (cmd_ready) add_expected(wr, addr, wdata, wstrb);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'h0, (n < 3000)}, 32'h1);
  endtask

  // Register-file responder: ready after a random wait, never while stalled.
  always @(negedge clk) begin
    if (!reg_req.valid || stall) begin
      dev_ready = 1'b0;
      if (!reg_req.valid) wait_left = int'($urandom_range(32'(max_wait)));
    end else if (wait_left == 0) begin
      dev_ready = 1'b1;
    end else begin
      dev_ready = 1'b0;
      wait_left--;
    end
  end

  always @(posedge clk) begin
    if (rst_n && reg_req.valid && dev_ready && reg_req.write && reg_req.addr < 32'h100)
      for (int b = 0; b < 4; b++)
        if (reg_req.wstrb[b]) dev_mem[reg_req.addr[7:2]][8*b +: 8] <= reg_req.wdata[8*b +: 8];
  end

  always_comb begin
    reg_rsp       = '0;
    reg_rsp.ready = dev_ready;
    reg_rsp.error = reg_req.valid && (reg_req.addr >= 32'h100);
    if (reg_req.valid && !reg_req.write && reg_req.addr < 32'h100)
      reg_rsp.rdata = dev_mem[reg_req.addr[7:2]] ^ corrupt;
  end

  // Response scoreboard: a response is checked on the cycle it is consumed.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rsp_ready = 1'b0;
    end else begin
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(3) != 0);
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", {31'h0, (exp_q.size() != 0)}, 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", {31'h0, rsp_error}, {31'h0, e.error});
          chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.timeout});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired observed=running expected=finished");
    failures++;
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    stall = 1'b0;
    hold_rsp = 1'b0;
    max_wait = 0;
    wait_left = 0;
    corrupt = '0;
    dev_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      model_mem[i] = '0;
      dev_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_req_valid", {31'h0, reg_req.valid}, 32'h0);
    chk("rst_req_addr", reg_req.addr, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    chk("rst_rsp_error", {31'h0, rsp_error}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'h0, cmd_ready}, 32'h1);

    // Latency of a write into an idle master: valid two cycles after the push.
    push_cmd(1'b1, 32'h08, 32'h299, 4'hF);
    @(negedge clk);
    chk("lat_w_valid_n1", {31'h0, reg_req.valid}, 32'h0);
    @(negedge clk);
    chk("lat_w_valid_n2", {31'h0, reg_req.valid}, 32'h1);
    chk("lat_w_addr", reg_req.addr, 32'h08);
    chk("lat_w_write", {31'h0, reg_req.write}, 32'h1);
    chk("lat_w_wdata", reg_req.wdata, 32'h299);
    chk("lat_w_wstrb", {28'h0, reg_req.wstrb}, 32'hF);
    drain();

    // Read with unaligned low address bits; response valid three cycles on.
    push_cmd(1'b0, 32'h0B, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("lat_r_valid_n2", {31'h0, reg_req.valid}, 32'h1);
    chk("lat_r_addr", reg_req.addr, 32'h0B);
    chk("lat_r_write", {31'h0, reg_req.write}, 32'h0);
    chk("lat_r_wdata", reg_req.wdata, 32'h0);
    chk("lat_r_wstrb", {28'h0, reg_req.wstrb}, 32'h0);
    @(negedge clk);
    chk("lat_r_rsp_n3", {31'h0, rsp_valid}, 32'h1);
    drain();

    // Partial write only touches strobed bytes.
    push_cmd(1'b1, 32'h00, 32'h1122_3344, 4'hF);
    push_cmd(1'b1, 32'h00, 32'h0000_00AB, 4'h1);
    push_cmd(1'b0, 32'h00, 32'h0, 4'h0);
    drain();

    // Unmapped write errors; the queued read behind it still runs.
    push_cmd(1'b1, 32'h1000, 32'h5555_5555, 4'hF);
    push_cmd(1'b0, 32'h08, 32'h0, 4'h0);
    drain();

    // Responder never ready: valid held for TimeoutCycles-1 cycles.
    stall = 1'b1;
    push_cmd(1'b1, 32'h10, 32'hCAFE_0001, 4'hF);
    n = 0;
    while (!reg_req.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (reg_req.valid && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_valid_cycles", 32'(n), 32'(Tmo - 1));
    drain();
    stall = 1'b0;

    // Full FIFO: one command parked in RSP plus four queued.
    max_wait = 0;
    hold_rsp = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 32'(8'h20 + 4 * i), 32'(i + 100), 4'hF);
    chk("full_ready_at_3", {31'h0, cmd_ready}, 32'h1);
    push_cmd(1'b1, 32'h30, 32'h104, 4'hF);
    chk("full_ready_at_4", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h24;
    repeat (3) @(negedge clk);
    chk("full_ready_held", {31'h0, cmd_ready}, 32'h0);
    chk("full_busy", {31'h0, busy}, 32'h1);
    cmd_valid = 1'b0;
    hold_rsp = 1'b0;
    push_cmd(1'b0, 32'h24, 32'h0, 4'h0);
    drain();

    // Corrupted read-back: flagged only when the verify pass is built in.
    corrupt = 32'h100;
    push_cmd(1'b1, 32'h08, 32'h299, 4'hF);
    drain();
    corrupt = '0;

    // Randomized traffic with random bus waits and response backpressure.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      max_wait = int'($urandom_range(3));
      a = ($urandom_range(7) == 0) ? 32'h1000 : 32'($urandom_range(15) * 4 + $urandom_range(3));
      push_cmd(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)));
      if ($urandom_range(3) == 0) repeat (int'($urandom_range(4))) @(negedge clk);
    end
    drain();
    max_wait = 0;

    // Async reset while a request is on the bus flushes everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(1'b1, 32'(4 * i), 32'hF00D, 4'hF);
    n = 0;
    while (!reg_req.valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_valid_before", {31'h0, reg_req.valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'h0, reg_req.valid}, 32'h0);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_req_valid", {31'h0, reg_req.valid}, 32'h0);
    chk("post_rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // Master still works after the flush.
    push_cmd(1'b0, 32'h08, 32'h0, 4'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
